// File: rtl/hash_receiver.sv
// ---------------------------------------------------------------------------
// hash_receiver
//   Receive end of the string-hash link. At reset it computes the 64-bit DJB2
//   hashes of the three dictionary words from the word ROMs, one character per
//   cycle. It then accepts 8-byte hashes (MSB first) over a valid/ready byte
//   interface and reports which dictionary word matched as a one-hot flag.
//
//   Ports:
//     Clock    in   1  rising-edge clock
//     Reset    in   1  asynchronous active-high reset
//     RxByte   in   8  incoming hash byte, most significant byte first
//     RxValid  in   1  RxByte valid this cycle
//     RxReady  out  1  a byte is accepted this cycle when RxValid is high
//     Z        out 64  last fully received hash
//     Wfound   out  3  match flags: bit2 word1, bit1 word2, bit0 word3
//     Done     out  1  one-cycle pulse when Z/Wfound update
//     NoMatch  out  1  last received hash matched no word
//
//   Also holds the shared character ROMs word1/word2/word3
//   (char out 8, index in 4; unused indices read 0).
// ---------------------------------------------------------------------------

module word1 (
    output logic [7:0] char,
    input  logic [3:0] index
);
    always_comb begin
        case (index)
            4'd0:    char = "a";
            4'd1:    char = "p";
            4'd2:    char = "p";
            4'd3:    char = "l";
            4'd4:    char = "e";
            4'd5:    char = "s";
            default: char = 8'h00;
        endcase
    end
endmodule

module word2 (
    output logic [7:0] char,
    input  logic [3:0] index
);
    always_comb begin
        case (index)
            4'd0:    char = "b";
            4'd1:    char = "a";
            4'd2:    char = "n";
            4'd3:    char = "a";
            4'd4:    char = "n";
            4'd5:    char = "a";
            4'd6:    char = "s";
            default: char = 8'h00;
        endcase
    end
endmodule

module word3 (
    output logic [7:0] char,
    input  logic [3:0] index
);
    always_comb begin
        case (index)
            4'd0:    char = "o";
            4'd1:    char = "r";
            4'd2:    char = "a";
            4'd3:    char = "n";
            4'd4:    char = "g";
            4'd5:    char = "e";
            4'd6:    char = "s";
            default: char = 8'h00;
        endcase
    end
endmodule

module hash_receiver #(
    parameter logic [63:0] SEED = 64'd5381,
    parameter int          LEN1 = 6,
    parameter int          LEN2 = 7,
    parameter int          LEN3 = 7
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  RxByte,
    input  logic        RxValid,
    output logic        RxReady,
    output logic [63:0] Z,
    output logic [2:0]  Wfound,
    output logic        Done,
    output logic        NoMatch
);

    typedef enum logic [1:0] {S_INIT, S_RECV, S_CMP} state_t;

    state_t      state_q;
    logic [1:0]  word_sel_q;
    logic [3:0]  idx_q;
    logic [2:0]  cnt_q;
    logic        rxready_q;
    logic [63:0] z_q;
    logic [2:0]  wfound_q;
    logic        done_q;
    logic        nomatch_q;

    logic [63:0] acc_q;
    logic [63:0] h1_q, h2_q, h3_q;
    logic [63:0] shift_q;

    logic [7:0]  c1, c2, c3;
    logic [7:0]  char_sel;
    logic [3:0]  last_idx;
    logic        last_char;
    logic [63:0] acc_base;
    logic [63:0] acc_d;

    word1 u_word1 (.char(c1), .index(idx_q));
    word2 u_word2 (.char(c2), .index(idx_q));
    word3 u_word3 (.char(c3), .index(idx_q));

    // The accumulator restarts from SEED at the first character of each word,
    // so it never needs a reset of its own.
    always_comb begin
        char_sel = c3;
        last_idx = 4'(LEN3 - 1);
        case (word_sel_q)
            2'd0: begin
                char_sel = c1;
                last_idx = 4'(LEN1 - 1);
            end
            2'd1: begin
                char_sel = c2;
                last_idx = 4'(LEN2 - 1);
            end
            default: begin
                char_sel = c3;
                last_idx = 4'(LEN3 - 1);
            end
        endcase
        last_char = (idx_q == last_idx);
        acc_base  = (idx_q == 4'd0) ? SEED : acc_q;
        acc_d     = (acc_base << 5) + acc_base + {56'd0, char_sel};
    end

    // Datapath registers: hash accumulation and the receive shift register.
    always_ff @(posedge Clock) begin
        if (state_q == S_INIT) begin
            acc_q <= acc_d;
            if (last_char) begin
                case (word_sel_q)
                    2'd0:    h1_q <= acc_d;
                    2'd1:    h2_q <= acc_d;
                    default: h3_q <= acc_d;
                endcase
            end
        end
        if (state_q == S_RECV && RxValid && rxready_q) begin
            shift_q <= {shift_q[55:0], RxByte};
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_INIT;
            word_sel_q <= 2'd0;
            idx_q      <= 4'd0;
            cnt_q      <= 3'd0;
            rxready_q  <= 1'b0;
            z_q        <= 64'd0;
            wfound_q   <= 3'b000;
            done_q     <= 1'b0;
            nomatch_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (last_char) begin
                        idx_q <= 4'd0;
                        if (word_sel_q == 2'd2) begin
                            word_sel_q <= 2'd0;
                            state_q    <= S_RECV;
                            rxready_q  <= 1'b1;
                        end else begin
                            word_sel_q <= word_sel_q + 2'd1;
                        end
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                S_RECV: begin
                    if (RxValid && rxready_q) begin
                        cnt_q <= cnt_q + 3'd1;
                        // 8th byte: counter wraps 7 -> 0
                        if (cnt_q == 3'd7) begin
                            state_q   <= S_CMP;
                            rxready_q <= 1'b0;
                        end
                    end
                end
                S_CMP: begin
                    z_q       <= shift_q;
                    wfound_q  <= {shift_q == h1_q, shift_q == h2_q, shift_q == h3_q};
                    nomatch_q <= !((shift_q == h1_q) || (shift_q == h2_q) || (shift_q == h3_q));
                    done_q    <= 1'b1;
                    state_q   <= S_RECV;
                    rxready_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_INIT;
                    rxready_q <= 1'b0;
                end
            endcase
        end
    end

    assign RxReady = rxready_q;
    assign Z       = z_q;
    assign Wfound  = wfound_q;
    assign Done    = done_q;
    assign NoMatch = nomatch_q;

endmodule

// File: tb/tb_hash_receiver.sv
module tb_hash_receiver;

    logic        Clock;
    logic        Reset;
    logic [7:0]  RxByte;
    logic        RxValid;
    logic        RxReady;
    logic [63:0] Z;
    logic [2:0]  Wfound;
    logic        Done;
    logic        NoMatch;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [63:0] H1, H2, H3;

    // Done events captured by the monitor
    logic [2:0]  q_wf[$];
    logic [63:0] q_z[$];
    logic        q_nm[$];
    int          q_cyc[$];

    hash_receiver dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .RxByte  (RxByte),
        .RxValid (RxValid),
        .RxReady (RxReady),
        .Z       (Z),
        .Wfound  (Wfound),
        .Done    (Done),
        .NoMatch (NoMatch)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            q_wf.push_back(Wfound);
            q_z.push_back(Z);
            q_nm.push_back(NoMatch);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: DJB2 of a character string, h = h*33 + c mod 2^64
    function automatic logic [63:0] djb2(input string s);
        logic [63:0] h;
        logic [7:0]  c;
        h = 64'd5381;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            h = h * 64'd33 + {56'd0, c};
        end
        return h;
    endfunction

    function automatic logic [2:0] ref_flags(input logic [63:0] v);
        return {v == H1, v == H2, v == H3};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte (after an idle gap) and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        RxValid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge Clock); #1;
        end
        RxValid = 1'b1;
        RxByte  = b;
        guard   = 0;
        while (RxReady !== 1'b1 && guard < 50) begin
            @(posedge Clock); #1;
            guard++;
        end
        if (RxReady !== 1'b1) begin
            n_cmp++;
            n_err++;
            $error("FAIL accept_timeout observed=%b expected=1", RxReady);
        end
        @(posedge Clock); #1;
        RxValid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] v, input int maxgap);
        for (int i = 7; i >= 0; i--) begin
            send_byte(v[i*8 +: 8], (i == 7) ? 0 : int'($urandom_range(maxgap)));
        end
    endtask

    task automatic get_result(output logic [2:0] wf, output logic [63:0] z,
                              output logic nm, output int c);
        int n;
        n = 0;
        while (q_wf.size() == 0 && n < 50) begin
            @(posedge Clock); #1;
            n++;
        end
        if (q_wf.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL result_timeout observed=none expected=Done");
            wf = 'x; z = 'x; nm = 1'bx; c = -1;
        end else begin
            wf = q_wf.pop_front();
            z  = q_z.pop_front();
            nm = q_nm.pop_front();
            c  = q_cyc.pop_front();
        end
    endtask

    // Count edges after reset release until RxReady rises; outputs stay 0.
    task automatic wait_init(input string tag);
        int  n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        while (RxReady !== 1'b1 && n < 100) begin
            @(posedge Clock); #1;
            n++;
            if (Z !== 64'd0 || Wfound !== 3'b000 || Done !== 1'b0 || NoMatch !== 1'b0)
                bad = 1'b1;
        end
        chk({tag, "_init_edges"}, 64'(n), 64'd20);
        chk({tag, "_init_outputs_quiet"}, 64'(bad), 64'd0);
    endtask

    logic [2:0]  wf_a, wf_b;
    logic [63:0] z_a, z_b, v;
    logic        nm_a, nm_b;
    int          c_a, c_b;

    initial begin
        Reset   = 1'b1;
        RxValid = 1'b0;
        RxByte  = 8'h00;
        H1 = djb2("apples");
        H2 = djb2("bananas");
        H3 = djb2("oranges");

        repeat (3) @(posedge Clock);
        #1;
        chk("rst_Z", Z, 64'd0);
        chk("rst_Wfound", 64'(Wfound), 64'd0);
        chk("rst_Done", 64'(Done), 64'd0);
        chk("rst_NoMatch", 64'(NoMatch), 64'd0);
        chk("rst_RxReady", 64'(RxReady), 64'd0);
        Reset = 1'b0;
        wait_init("boot");

        // RxValid held during INIT is ignored: nothing accepted
        // word1, back-to-back, exact latency and pulse width
        q_wf.delete(); q_z.delete(); q_nm.delete(); q_cyc.delete();
        send_frame(H1, 0);
        chk("w1_cmp_ready_low", 64'(RxReady), 64'd0);
        chk("w1_done_early", 64'(Done), 64'd0);
        @(posedge Clock); #1;
        chk("w1_done", 64'(Done), 64'd1);
        chk("w1_wfound", 64'(Wfound), 64'(3'b100));
        chk("w1_nomatch", 64'(NoMatch), 64'd0);
        chk("w1_Z", Z, H1);
        @(posedge Clock); #1;
        chk("w1_done_clear", 64'(Done), 64'd0);
        chk("w1_ready_back", 64'(RxReady), 64'd1);
        chk("w1_wfound_hold", 64'(Wfound), 64'(3'b100));
        q_wf.delete(); q_z.delete(); q_nm.delete(); q_cyc.delete();

        // word2 and word3
        send_frame(H2, 0);
        get_result(wf_a, z_a, nm_a, c_a);
        chk("w2_wfound", 64'(wf_a), 64'(3'b010));
        chk("w2_Z", z_a, H2);
        chk("w2_nomatch", 64'(nm_a), 64'd0);
        send_frame(H3, 0);
        get_result(wf_a, z_a, nm_a, c_a);
        chk("w3_wfound", 64'(wf_a), 64'(3'b001));
        chk("w3_Z", z_a, H3);

        // SEED matches nothing
        send_frame(64'h1505, 0);
        get_result(wf_a, z_a, nm_a, c_a);
        chk("seed_wfound", 64'(wf_a), 64'd0);
        chk("seed_nomatch", 64'(nm_a), 64'd1);
        chk("seed_Z", z_a, 64'h1505);

        // word2 with random gaps; its first byte is held through the CMP
        // cycle of the preceding word1 frame
        send_frame(H1, 0);
        send_frame(H2, 5);
        get_result(wf_a, z_a, nm_a, c_a);
        get_result(wf_b, z_b, nm_b, c_b);
        chk("gap_prev_wfound", 64'(wf_a), 64'(3'b100));
        chk("gap_wfound", 64'(wf_b), 64'(3'b010));
        chk("gap_Z", z_b, H2);

        // partial frame, then reset
        @(posedge Clock); #1;
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        Reset = 1'b1;
        #1;
        chk("midrst_Z", Z, 64'd0);
        chk("midrst_Wfound", 64'(Wfound), 64'd0);
        chk("midrst_RxReady", 64'(RxReady), 64'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        wait_init("midrst");
        q_wf.delete(); q_z.delete(); q_nm.delete(); q_cyc.delete();
        send_frame(H3, 0);
        get_result(wf_a, z_a, nm_a, c_a);
        chk("midrst_w3_wfound", 64'(wf_a), 64'(3'b001));
        chk("midrst_w3_Z", z_a, H3);

        // back-to-back frames
        send_frame(H1, 0);
        send_frame(H3, 0);
        get_result(wf_a, z_a, nm_a, c_a);
        get_result(wf_b, z_b, nm_b, c_b);
        chk("b2b_first", 64'(wf_a), 64'(3'b100));
        chk("b2b_second", 64'(wf_b), 64'(3'b001));
        chk("b2b_period", 64'(c_b - c_a), 64'd9);

        // random values against the reference model
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(3))
                0:       v = H1;
                1:       v = H2;
                2:       v = H3;
                default: v = {$urandom, $urandom};
            endcase
            send_frame(v, 3);
            get_result(wf_a, z_a, nm_a, c_a);
            chk("rand_wfound", 64'(wf_a), 64'(ref_flags(v)));
            chk("rand_nomatch", 64'(nm_a), 64'(ref_flags(v) == 3'b000));
            chk("rand_Z", z_a, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hash_receiver.md
# hash_receiver

Receive end of the string-hash link. Accepts a 64-bit DJB2 hash as eight bytes over a valid/ready byte interface, then compares it against the hashes of the three known words. It reports which word was transmitted as a one-hot `Wfound`, the same encoding the transmit side consumes. The reference hashes are computed on-chip after reset from the shared `word1`/`word2`/`word3` character ROMs, so both ends always agree on the dictionary.

## Interface
Parameters:
- `SEED`, 64'd5381: DJB2 initial hash value.
- `LEN1`, 6: character count of word1.
- `LEN2`, 7: character count of word2.
- `LEN3`, 7: character count of word3.

Ports:
- `Clock`, input, 1: single clock; all state changes on the rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `RxByte`, input, 8: incoming hash byte, most significant byte first.
- `RxValid`, input, 1: `RxByte` is valid this cycle.
- `RxReady`, output, 1: the block accepts a byte this cycle.
- `Z`, output, 64: last fully received hash.
- `Wfound`, output, 3: match flags; bit2 = word1, bit1 = word2, bit0 = word3.
- `Done`, output, 1: one-cycle pulse when `Wfound`/`Z` update.
- `NoMatch`, output, 1: last received hash matched no word.

## Operation
- Reset values: `Z`=0, `Wfound`=3'b000, `Done`=0, `NoMatch`=0, `RxReady`=0, byte count=0, state=INIT.
- Word ROMs are instantiated as `wordN(char, index)`, with an 8-bit char and a 4-bit index. Index runs from 0 to LENn-1.
- State INIT computes H1, H2, H3 in sequence, one character per cycle:
  - For each word, H starts at `SEED`.
  - Each character updates H = (H<<5) + H + {56'b0, char}, modulo 2^64. No wider intermediate is kept.
  - All logic is rising-edge only; there is no negedge staging.
  - INIT lasts LEN1+LEN2+LEN3 cycles (20 at defaults), then the block moves to RECV.
  - `RxValid` is ignored in INIT.
- State RECV:
  - `RxReady`=1.
  - On each edge with `RxValid`&&`RxReady`: shift register ← {shift[55:0], RxByte}, count++.
  - On acceptance of the 8th byte (count 7→0 wrap), the next state is CMP.
- State CMP (one cycle):
  - `RxReady`=0.
  - On the exiting edge: `Z` ← shift register; `Wfound[2]` ← (shift==H1), `Wfound[1]` ← (shift==H2), `Wfound[0]` ← (shift==H3).
  - `NoMatch` ← no bit set; `Done` ← 1.
  - The state returns to RECV.
- `Done` is cleared on the following edge. `Wfound`, `Z` and `NoMatch` hold until the next CMP.
- More than one `Wfound` bit may be set if dictionary hashes collide. The block reports the raw comparisons and does not prioritize.
- Reset asserted mid-frame or mid-INIT discards partial bytes and restarts INIT. Outputs return to their reset values immediately (asynchronous).
- `RxByte` is sampled only when `RxValid`&&`RxReady`. Gaps between bytes of any length are legal; the frame resumes where it stopped.

## Timing
- After `Reset` falls, `RxReady` first reads 1 after LEN1+LEN2+LEN3 rising edges (20 at defaults).
- Byte acceptance takes 1 cycle per byte; back-to-back bytes are allowed.
- Let edge E accept the 8th byte. CMP occupies the cycle after E, and `Done`/`Wfound` are visible after edge E+1.
- `Done` is high for exactly one cycle. `RxReady` is low for exactly that CMP cycle (E to E+1), then high again.
- Minimum frame period is 9 cycles.
- A byte presented with `RxValid` during CMP is not accepted. The sender must hold it until `RxReady`=1.

## Test plan
- Reset, then count edges until `RxReady` rises. It must be high after exactly 20 edges; all outputs stay 0 until then.
- Send the bench-computed DJB2 of word1 as 8 back-to-back bytes, MSB first. Response: one cycle later `Done`=1, `Wfound`=3'b100, `NoMatch`=0, and `Z` equals the sent value. Repeat for word2 (3'b010) and word3 (3'b001).
- Send 0x0000000000001505 (`SEED`). Response: `Done` pulses, `Wfound`=3'b000, `NoMatch`=1, `Z`=64'h1505.
- Send a word2 hash with random 0–5 cycle `RxValid` gaps, and hold `RxValid` during the CMP cycle of the preceding frame. Response: no byte is lost or duplicated, and `Wfound`=3'b010.
- Send 4 bytes, assert `Reset` for 1 cycle, wait 20 cycles, then send the full word3 hash. Response: `Wfound`=3'b001; the stale partial bytes have no effect.
- Send back-to-back frames word1 then word3 with no idle. Response: `Done` pulses exactly 9 cycles apart, and `Wfound` changes 3'b100 → 3'b001.
